// File: rtl/cp0_exc_if.sv
// -----------------------------------------------------------------------------
// cp0_exc_if
// Bundle of the M-stage signals exchanged between the pipeline and the
// coprocessor-0 exception/interrupt unit.
//   master : pipeline side. It drives the mfc0/mtc0 accesses, the PC/BD of
//            the M instruction, the exception code, the interrupt lines and
//            eret. It receives IntReq, EPC_out and DOut.
//   slave  : CP0 side, with the directions mirrored.
// -----------------------------------------------------------------------------
interface cp0_exc_if;
    logic [4:0]  A1;          // mfc0 read register number
    logic [4:0]  A2;          // mtc0 write register number
    logic [31:0] DIn;         // mtc0 write data
    logic        We;          // mtc0 write enable
    logic [31:0] PC;          // PC of the instruction in M
    logic        BD;          // M instruction is in a branch delay slot
    logic [6:2]  ExcCode_in;  // M-stage exception code, 0 = none
    logic [7:2]  HWInt;       // level-sensitive external interrupt lines
    logic        EXLClr;      // eret in M
    logic        IntReq;      // take a trap this cycle
    logic [31:0] EPC_out;     // current EPC
    logic [31:0] DOut;        // mfc0 read data

    modport master (
        output A1, A2, DIn, We, PC, BD, ExcCode_in, HWInt, EXLClr,
        input  IntReq, EPC_out, DOut
    );

    modport slave (
        input  A1, A2, DIn, We, PC, BD, ExcCode_in, HWInt, EXLClr,
        output IntReq, EPC_out, DOut
    );
endinterface

// File: rtl/cp0_exc_unit.sv
// -----------------------------------------------------------------------------
// cp0_exc_unit
// Coprocessor-0 exception/interrupt unit for the five-stage MIPS32 pipeline.
// This block decides whether the instruction in M traps, either on an enabled
// hardware interrupt or on an M-stage exception code. On a trap it records
// SR.EXL, Cause.BD/ExcCode and EPC. It also serves mfc0 reads and mtc0
// writes, and clears EXL on eret.
//
// Ports
//   clk    : pipeline clock; all state changes on the rising edge
//   reset  : synchronous, active-low
//   bus    : cp0_exc_if.slave. It carries A1/A2/DIn/We (mfc0/mtc0),
//            PC/BD/ExcCode_in (M-stage trap source), HWInt, EXLClr (eret),
//            IntReq (combinational trap request), EPC_out and DOut
//            (combinational mfc0 read data).
// -----------------------------------------------------------------------------
module cp0_exc_unit #(
    parameter logic [31:0] PRID = 32'h4554_4850
) (
    input logic       clk,
    input logic       reset,
    cp0_exc_if.slave  bus
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // Architectural state. Only the implemented bits are stored.
    logic [5:0]  sr_im_q,     sr_im_d;
    logic        sr_exl_q,    sr_exl_d;
    logic        sr_ie_q,     sr_ie_d;
    logic        cause_bd_q,  cause_bd_d;
    logic [5:0]  cause_ip_q,  cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [29:0] epc_q,       epc_d;        // word address, low two bits are 0

    logic        int_hit;
    logic        exc_hit;
    logic        int_req;
    logic        mtc0_we;
    logic [4:0]  trap_code;
    logic [31:0] trap_pc;
    logic [31:0] sr_word;
    logic [31:0] cause_word;
    logic [31:0] epc_word;
    logic [31:0] dout;

    // Trap decision. It uses the live HWInt and the current SR only.
    always_comb begin
        int_hit   = (|(bus.HWInt & sr_im_q)) & sr_ie_q & ~sr_exl_q;
        exc_hit   = (bus.ExcCode_in != 5'd0) & ~sr_exl_q;
        int_req   = int_hit | exc_hit;
        // An interrupt outranks a coincident exception and records code 0.
        trap_code = int_hit ? 5'd0 : bus.ExcCode_in;
        // A trap in a delay slot restarts at the branch. The subtraction is
        // modulo 2^32, so PC = 0 wraps to 32'hFFFF_FFFC.
        trap_pc   = bus.BD ? (bus.PC - 32'd4) : bus.PC;
        // A trap takes precedence over a same-cycle mtc0.
        mtc0_we   = bus.We & ~int_req;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every _d gets a default "hold" value first, so that no path
        // through the if/else tree leaves a signal unassigned and infers a latch.
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
        // IP tracks the interrupt lines every cycle, whatever else happens.
        cause_ip_d  = bus.HWInt;

        if (int_req) begin
            sr_exl_d    = 1'b1;
            cause_bd_d  = bus.BD;
            cause_exc_d = trap_code;
            epc_d       = trap_pc[31:2];
        end else begin
            if (mtc0_we && bus.A2 == REG_SR) begin
                sr_im_d  = bus.DIn[15:10];
                sr_exl_d = bus.DIn[1];
                sr_ie_d  = bus.DIn[0];
            end
            if (mtc0_we && bus.A2 == REG_EPC) begin
                epc_d = bus.DIn[31:2];
            end
            // eret overrides an mtc0 to SR for the EXL bit only.
            if (bus.EXLClr) begin
                sr_exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments only. Every flop
        // then samples the pre-edge values, whatever the statement order.
        if (!reset) begin
            sr_im_q     <= '0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= '0;
            cause_exc_q <= '0;
            epc_q       <= '0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

    // Architectural register views. Unimplemented bits read as 0.
    always_comb begin
        sr_word    = {16'b0, sr_im_q, 8'b0, sr_exl_q, sr_ie_q};
        cause_word = {cause_bd_q, 15'b0, cause_ip_q, 3'b0, cause_exc_q, 2'b0};
        epc_word   = {epc_q, 2'b00};
        case (bus.A1)
            REG_SR:    dout = sr_word;
            REG_CAUSE: dout = cause_word;
            REG_EPC:   dout = epc_word;
            REG_PRID:  dout = PRID;
            default:   dout = 32'd0;
        endcase
    end

    assign bus.IntReq  = int_req;
    assign bus.EPC_out = epc_word;
    assign bus.DOut    = dout;

endmodule
